// File: rtl/y86_cc_unit_if.sv
// rtl/y86_cc_unit_if.sv - execute-stage bus between the ALU/decode side and the condition-code unit
interface y86_cc_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [3:0]       alu_fun;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_e;
    logic             set_cc;
    logic [3:0]       cond_fn;
    logic [2:0]       cc_out;
    logic             cnd;
    logic             out_valid;
    logic             err;

    modport master (
        output in_valid, alu_fun, alu_a, alu_b, alu_e, set_cc, cond_fn,
        input  cc_out, cnd, out_valid, err
    );

    modport slave (
        input  in_valid, alu_fun, alu_a, alu_b, alu_e, set_cc, cond_fn,
        output cc_out, cnd, out_valid, err
    );
endinterface

// File: rtl/y86_cc_unit.sv
// rtl/y86_cc_unit.sv - Y86 SEQ condition-code register and cmovXX/jXX condition evaluator
module y86_cc_unit #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    y86_cc_unit_if.slave  bus
);
    logic       w_msb_a;
    logic       w_msb_b;
    logic       w_msb_e;
    logic       w_zf;
    logic       w_sf;
    logic       w_of;
    logic       w_fun_ok;
    logic       w_cc_we;
    logic       w_err;
    logic       w_cnd_eval;
    logic       w_lt;

    logic [2:0] r_cc;
    logic       r_cnd;
    logic       r_out_valid;
    logic       r_err;

    assign w_msb_a  = bus.alu_a[WIDTH-1];
    assign w_msb_b  = bus.alu_b[WIDTH-1];
    assign w_msb_e  = bus.alu_e[WIDTH-1];
    assign w_zf     = (bus.alu_e == '0);
    assign w_sf     = w_msb_e;
    assign w_fun_ok = (bus.alu_fun <= 4'd3);
    assign w_cc_we  = bus.in_valid & bus.set_cc & w_fun_ok;
    assign w_err    = bus.in_valid & bus.set_cc & ~w_fun_ok;

    // Overflow is inferred from the operand/result sign bits; the ALU result is trusted as-is.
    always_comb begin
        w_of = 1'b0;
        case (bus.alu_fun)
            4'd0:    w_of = (w_msb_a == w_msb_b) & (w_msb_e != w_msb_a);
            4'd1:    w_of = (w_msb_a != w_msb_b) & (w_msb_e != w_msb_b);
            default: w_of = 1'b0;
        endcase
    end

    // Evaluated against the registered flags so an OPq on the same edge cannot affect it.
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cnd_eval = 1'b0;
        case (bus.cond_fn)
            4'd0:    w_cnd_eval = 1'b1;
            4'd1:    w_cnd_eval = w_lt | r_cc[2];
            4'd2:    w_cnd_eval = w_lt;
            4'd3:    w_cnd_eval = r_cc[2];
            4'd4:    w_cnd_eval = ~r_cc[2];
            4'd5:    w_cnd_eval = ~w_lt;
            4'd6:    w_cnd_eval = ~w_lt & ~r_cc[2];
            default: w_cnd_eval = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc <= 3'b100;
        end else if (w_cc_we) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnd       <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            r_err       <= w_err;
            if (bus.in_valid) begin
                r_cnd <= w_cnd_eval;
            end
        end
    end

    assign bus.cc_out    = r_cc;
    assign bus.cnd       = r_cnd;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_y86_cc_unit.sv
// tb/tb_y86_cc_unit.sv - scoreboard bench for the Y86 condition-code unit
module tb_y86_cc_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    y86_cc_unit_if #(.WIDTH(64)) bus ();

    y86_cc_unit #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [1:0] sb_q[$];
    logic [2:0] m_cc;
    logic [1:0] ex;

    localparam logic [63:0] PAT_A  = {32{2'b10}};
    localparam logic [63:0] PAT_5  = {32{2'b01}};
    localparam logic [63:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [2:0] model_flags(input logic [3:0] fun, input logic [63:0] a,
                                               input logic [63:0] b, input logic [63:0] e);
        logic of;
        of = 1'b0;
        if (fun == 4'd0) of = (a[63] == b[63]) && (e[63] != a[63]);
        if (fun == 4'd1) of = (a[63] != b[63]) && (e[63] != b[63]);
        return {(e == 64'd0), e[63], of};
    endfunction

    function automatic logic model_cond(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        {zf, sf, of} = cc;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return (sf ^ of) | zf;
            4'd2: return sf ^ of;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !(sf ^ of);
            4'd6: return !(sf ^ of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] pop_exp();
        if (sb_q.size() == 0) return 2'bxx;
        return sb_q.pop_front();
    endfunction

    task automatic drive(input logic v, input logic [3:0] fun, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] e, input logic sc,
                         input logic [3:0] cf);
        @(negedge clk);
        bus.in_valid = v;
        bus.alu_fun  = fun;
        bus.alu_a    = a;
        bus.alu_b    = b;
        bus.alu_e    = e;
        bus.set_cc   = sc;
        bus.cond_fn  = cf;
        if (v) begin
            sb_q.push_back({model_cond(cf, m_cc), sc && (fun > 4'd3)});
            if (sc && fun <= 4'd3) m_cc = model_flags(fun, a, b, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.alu_fun = 4'd0; bus.alu_a = '0; bus.alu_b = '0;
        bus.alu_e = '0; bus.set_cc = 1'b0; bus.cond_fn = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_cc = 3'b100;
        sb_q.delete();
        drive(1'b1, 4'd0, 64'd1, 64'd2, 64'd3, 1'b1, 4'd0);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err} !== {1'b1, ex}) begin
            n_fails++;
            $display("FAIL reset_pre_out: got %b expected %b", {bus.out_valid, bus.cnd, bus.err}, {1'b1, ex});
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.cc_out, bus.cnd, bus.out_valid, bus.err} !== 6'b100_000) begin
            n_fails++;
            $display("FAIL reset_async: got %b expected 100000", {bus.cc_out, bus.cnd, bus.out_valid, bus.err});
        end
        @(negedge clk);
        rst = 1'b0;
        m_cc = 3'b100;
        sb_q.delete();
        drive(1'b1, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 4'd3);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err} !== {1'b1, ex} || bus.cnd !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_cond_e: got %b expected %b", {bus.out_valid, bus.cnd, bus.err}, 3'b110);
        end
    endtask

    task automatic test_zero_and();
        drive(1'b1, 4'd0, 64'd5, 64'd6, 64'd11, 1'b1, 4'd0);
        ex = pop_exp();
        n_checks++;
        if (bus.cc_out !== 3'b000) begin
            n_fails++;
            $display("FAIL and_setup_cc: got %b expected 000", bus.cc_out);
        end
        drive(1'b1, 4'd2, PAT_A, PAT_5, 64'd0, 1'b1, 4'd0);
        ex = pop_exp();
        n_checks++;
        if (bus.cc_out !== 3'b100) begin
            n_fails++;
            $display("FAIL and_zero_cc: got %b expected 100", bus.cc_out);
        end
        drive(1'b1, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 4'd4);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err} !== {1'b1, ex} || bus.cnd !== 1'b0) begin
            n_fails++;
            $display("FAIL and_cond_ne: got %b expected 100", {bus.out_valid, bus.cnd, bus.err});
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 4'd0, MAXPOS, MAXPOS, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd0);
        ex = pop_exp();
        n_checks++;
        if (bus.cc_out !== 3'b011) begin
            n_fails++;
            $display("FAIL add_ovf_cc: got %b expected 011", bus.cc_out);
        end
        drive(1'b1, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 4'd2);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err} !== {1'b1, ex} || bus.cnd !== 1'b0) begin
            n_fails++;
            $display("FAIL add_ovf_l: got %b expected 100", {bus.out_valid, bus.cnd, bus.err});
        end
        drive(1'b1, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 4'd5);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err} !== {1'b1, ex} || bus.cnd !== 1'b1) begin
            n_fails++;
            $display("FAIL add_ovf_ge: got %b expected 110", {bus.out_valid, bus.cnd, bus.err});
        end
    endtask

    task automatic test_sub_overflow();
        drive(1'b1, 4'd1, 64'd1, MINNEG, MAXPOS, 1'b1, 4'd0);
        ex = pop_exp();
        n_checks++;
        if (bus.cc_out !== 3'b001) begin
            n_fails++;
            $display("FAIL sub_ovf_cc: got %b expected 001", bus.cc_out);
        end
        drive(1'b1, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 4'd1);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err} !== {1'b1, ex} || bus.cnd !== 1'b1) begin
            n_fails++;
            $display("FAIL sub_ovf_le: got %b expected 110", {bus.out_valid, bus.cnd, bus.err});
        end
    endtask

    task automatic test_old_flags();
        drive(1'b1, 4'd3, 64'd7, 64'd7, 64'd0, 1'b1, 4'd0);
        ex = pop_exp();
        n_checks++;
        if (bus.cc_out !== 3'b100) begin
            n_fails++;
            $display("FAIL old_setup_cc: got %b expected 100", bus.cc_out);
        end
        drive(1'b1, 4'd3, PAT_A, PAT_5, ONES, 1'b1, 4'd3);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err, bus.cc_out} !== {1'b1, ex, 3'b010} || bus.cnd !== 1'b1) begin
            n_fails++;
            $display("FAIL old_flag_cnd_cc: got %b expected 110010", {bus.out_valid, bus.cnd, bus.err, bus.cc_out});
        end
    endtask

    task automatic test_invalid_fun();
        drive(1'b1, 4'd7, 64'd0, 64'd0, 64'd0, 1'b1, 4'd0);
        ex = pop_exp();
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err, bus.cc_out} !== {1'b1, ex, 3'b010} || bus.err !== 1'b1) begin
            n_fails++;
            $display("FAIL invalid_fun: got %b expected 111010", {bus.out_valid, bus.cnd, bus.err, bus.cc_out});
        end
        drive(1'b0, 4'd0, 64'd1, 64'd1, 64'd0, 1'b1, 4'd4);
        n_checks++;
        if ({bus.out_valid, bus.cnd, bus.err, bus.cc_out} !== 6'b010_010) begin
            n_fails++;
            $display("FAIL idle_set_cc: got %b expected 010010", {bus.out_valid, bus.cnd, bus.err, bus.cc_out});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  fun, cf;
        logic [63:0] a, b, e;
        logic        v, sc;
        for (int i = 0; i < 40; i++) begin
            fun = 4'($urandom_range(0, 5));
            cf  = 4'($urandom_range(0, 8));
            v   = ($urandom_range(0, 7) != 0);
            sc  = ($urandom_range(0, 3) != 0);
            a   = {$urandom, $urandom};
            b   = (i % 5 == 0) ? a : {$urandom, $urandom};
            if (i % 7 == 3) a[63] = b[63];
            case (fun)
                4'd0:    e = b + a;
                4'd1:    e = b - a;
                4'd2:    e = b & a;
                default: e = b ^ a;
            endcase
            drive(v, fun, a, b, e, sc, cf);
            n_checks++;
            if (v) begin
                ex = pop_exp();
                if ({bus.out_valid, bus.cnd, bus.err, bus.cc_out} !== {1'b1, ex, m_cc}) begin
                    n_fails++;
                    $display("FAIL b2b_%0d: got %b expected %b", i, {bus.out_valid, bus.cnd, bus.err, bus.cc_out}, {1'b1, ex, m_cc});
                end
            end else if ({bus.out_valid, bus.err, bus.cc_out} !== {2'b00, m_cc}) begin
                n_fails++;
                $display("FAIL b2b_idle_%0d: got %b expected %b", i, {bus.out_valid, bus.err, bus.cc_out}, {2'b00, m_cc});
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_and();
        test_add_overflow();
        test_sub_overflow();
        test_old_flags();
        test_invalid_fun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
